// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data ports onto one 64-bit fixed-latency memory, one access at a time.
// Build option: define MEM_ARB_DPRIO_EN for fixed data priority instead of round-robin.
module mem_port_arbiter #(
  parameter int I_ADDR_BITS = 6,
  parameter int D_ADDR_BITS = 6,
  parameter int M_ADDR_BITS = 4,
  parameter int LATENCY     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_req,
  input  logic [I_ADDR_BITS-1:0] i_addr,
  output logic                   i_ack,
  output logic [31:0]            i_rdata,
  input  logic                   d_req,
  input  logic                   d_we,
  input  logic [D_ADDR_BITS-1:0] d_addr,
  input  logic [63:0]            d_wdata,
  output logic                   d_ack,
  output logic [63:0]            d_rdata,
  output logic                   m_en,
  output logic                   m_we,
  output logic [M_ADDR_BITS-1:0] m_addr,
  output logic [63:0]            m_wdata,
  input  logic [63:0]            m_rdata,
  output logic                   busy
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT, S_ACK} state_t;

  localparam int IW = M_ADDR_BITS + I_ADDR_BITS;
  localparam int DW = M_ADDR_BITS + D_ADDR_BITS;

  state_t                 state_q, state_d;
  logic                   grant_d_q, grant_d_d;
  logic                   sel_hi_q, sel_hi_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   m_en_q, m_en_d;
  logic                   m_we_q, m_we_d;
  logic [M_ADDR_BITS-1:0] m_addr_q, m_addr_d;
  logic [63:0]            m_wdata_q, m_wdata_d;
  logic                   i_ack_q, i_ack_d;
  logic                   d_ack_q, d_ack_d;
  logic [31:0]            i_rdata_q, i_rdata_d;
  logic [63:0]            d_rdata_q, d_rdata_d;
  logic                   busy_q, busy_d;
  logic                   grant_data;
`ifndef MEM_ARB_DPRIO_EN
  logic                   last_grant_q, last_grant_d;  // 1 = data was granted last
`endif

  // Byte address to doubleword address, zero-extended before the shift so
  // narrow ports and wide memories both resize cleanly.
  logic [IW-1:0] i_wide;
  logic [DW-1:0] d_wide;
  assign i_wide = IW'(i_addr) >> 3;
  assign d_wide = DW'(d_addr) >> 3;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_wide[IW-1:M_ADDR_BITS], d_wide[DW-1:M_ADDR_BITS]};

`ifdef MEM_ARB_DPRIO_EN
  assign grant_data = d_req;
`else
  assign grant_data = d_req && (!i_req || !last_grant_q);
`endif

  always_comb begin
    state_d   = state_q;
    grant_d_d = grant_d_q;
    sel_hi_d  = sel_hi_q;
    cnt_d     = cnt_q;
    m_en_d    = 1'b0;
    m_we_d    = 1'b0;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
`ifndef MEM_ARB_DPRIO_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          grant_d_d = grant_data;
`ifndef MEM_ARB_DPRIO_EN
          last_grant_d = grant_data;
`endif
          sel_hi_d  = i_addr[2];
          m_en_d    = 1'b1;
          m_we_d    = grant_data && d_we;
          m_addr_d  = grant_data ? d_wide[M_ADDR_BITS-1:0] : i_wide[M_ADDR_BITS-1:0];
          if (grant_data) m_wdata_d = d_wdata;
          state_d   = S_CMD;
        end
      end
      S_CMD: begin
        if (m_we_q) begin
          d_ack_d = 1'b1;
          state_d = S_ACK;
        end else begin
          cnt_d   = 4'(LATENCY - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // The final WAIT cycle is exactly LATENCY cycles after CMD.
        if (cnt_q == 4'd0) begin
          if (grant_d_q) d_rdata_d = m_rdata;
          else           i_rdata_d = sel_hi_q ? m_rdata[63:32] : m_rdata[31:0];
          d_ack_d = grant_d_q;
          i_ack_d = !grant_d_q;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      grant_d_q <= 1'b0;
      sel_hi_q  <= 1'b0;
      cnt_q     <= 4'd0;
      m_en_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= 64'd0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= 32'd0;
      d_rdata_q <= 64'd0;
      busy_q    <= 1'b0;
`ifndef MEM_ARB_DPRIO_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_d_q <= grant_d_d;
      sel_hi_q  <= sel_hi_d;
      cnt_q     <= cnt_d;
      m_en_q    <= m_en_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      busy_q    <= busy_d;
`ifndef MEM_ARB_DPRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign m_en    = m_en_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign busy    = busy_q;

endmodule
